// File: rtl/mem_stage_lsu.sv
// RV32I memory-access stage with MEM/WB pipeline register: issues loads/stores on a
// ready/request port, formats load data and reports misaligned/illegal/timeout exceptions.
module mem_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VALID_IN,
    input  logic        MEM_RD,
    input  logic        MEM_WR,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    input  logic        CRT_WB_IN,
    input  logic [4:0]  RD_ADDR_IN,
    input  logic        REG_WE_IN,
    output logic        STALL,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_BE,
    output logic [31:0] DMEM_WDATA,
    input  logic        DMEM_READY,
    input  logic [31:0] DMEM_RDATA,
    output logic        VALID_OUT,
    output logic [31:0] DATA_M,
    output logic [31:0] DATA_E,
    output logic        CRT_WB,
    output logic [4:0]  RD_ADDR_OUT,
    output logic        REG_WE_OUT,
    output logic [1:0]  EXC_OUT
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;

    logic [2:0]     f3_reg;
    logic [31:0]    addr_reg;
    logic [31:0]    sdata_reg;
    logic           wr_reg;
    logic           crt_reg;
    logic [4:0]     rd_reg;
    logic           we_reg;

    logic           valid_out_reg;
    logic [31:0]    data_m_reg;
    logic [31:0]    data_e_reg;
    logic           crt_wb_reg;
    logic [4:0]     rd_out_reg;
    logic           reg_we_out_reg;
    logic [1:0]     exc_reg;

    logic           mem_op, illegal, misaligned, start;
    logic           in_access, done, timeout_hit;
    logic [7:0]     lane_bytes [4];
    logic [3:0]     sb_be;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    load_fmt;

    // ------------------------------------------------------------------
    // Decode of the EX/MEM slot
    // ------------------------------------------------------------------
    assign mem_op = VALID_IN & (MEM_RD | MEM_WR);

    always_comb begin
        illegal = 1'b0;
        if (MEM_RD && MEM_WR)
            illegal = 1'b1;
        else if (MEM_RD)
            illegal = !(FUNCT3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else if (MEM_WR)
            illegal = !(FUNCT3 inside {3'b000, 3'b001, 3'b010});
    end

    assign misaligned = ((FUNCT3[1:0] == 2'b01) & ADDR[0]) |
                        ((FUNCT3[1:0] == 2'b10) & (ADDR[1:0] != 2'b00));

    assign start       = (state_reg == IDLE) & mem_op & !illegal & !misaligned;
    assign in_access   = (state_reg == ACCESS);
    assign done        = in_access & DMEM_READY;
    assign timeout_hit = (TIMEOUT != 0) & in_access & !DMEM_READY & (cnt_reg == TO_LAST);

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        case (state_reg)
            IDLE:   if (start) state_next = ACCESS;
            ACCESS: begin
                if (done || timeout_hit)
                    state_next = IDLE;
                else
                    cnt_next = cnt_reg + CW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte-lane helpers shared by store enables and load extraction
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_bytes[gi] = DMEM_RDATA[8*gi +: 8];
        assign sb_be[gi]      = (addr_reg[1:0] == 2'(gi));
    end

    always_comb begin
        STALL      = 1'b0;
        DMEM_REQ   = 1'b0;
        DMEM_WE    = 1'b0;
        DMEM_ADDR  = {addr_reg[31:2], 2'b00};
        DMEM_BE    = 4'b1111;
        DMEM_WDATA = sdata_reg;
        if (!RST) begin
            STALL    = start | (in_access & !DMEM_READY & !timeout_hit);
            DMEM_REQ = in_access;
            DMEM_WE  = in_access & wr_reg;
        end
        if (wr_reg) begin
            case (f3_reg[1:0])
                2'b00: begin
                    DMEM_BE    = sb_be;
                    DMEM_WDATA = {4{sdata_reg[7:0]}};
                end
                2'b01: begin
                    DMEM_BE    = addr_reg[1] ? 4'b1100 : 4'b0011;
                    DMEM_WDATA = {2{sdata_reg[15:0]}};
                end
                default: begin
                    DMEM_BE    = 4'b1111;
                    DMEM_WDATA = sdata_reg;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load data formatting
    // ------------------------------------------------------------------
    assign ld_byte = lane_bytes[addr_reg[1:0]];
    assign ld_half = addr_reg[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];

    always_comb begin
        case (f3_reg)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_fmt = {24'd0, ld_byte};
            3'b101:  load_fmt = {16'd0, ld_half};
            default: load_fmt = DMEM_RDATA;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture registers for the outstanding access
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            f3_reg    <= '0;
            addr_reg  <= '0;
            sdata_reg <= '0;
            wr_reg    <= 1'b0;
            crt_reg   <= 1'b0;
            rd_reg    <= '0;
            we_reg    <= 1'b0;
        end else if (start) begin
            f3_reg    <= FUNCT3;
            addr_reg  <= ADDR;
            sdata_reg <= STORE_DATA;
            wr_reg    <= MEM_WR;
            crt_reg   <= CRT_WB_IN;
            rd_reg    <= RD_ADDR_IN;
            we_reg    <= REG_WE_IN;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_out_reg  <= 1'b0;
            data_m_reg     <= '0;
            data_e_reg     <= '0;
            crt_wb_reg     <= 1'b0;
            rd_out_reg     <= '0;
            reg_we_out_reg <= 1'b0;
            exc_reg        <= 2'b00;
        end else if (in_access) begin
            if (done || timeout_hit) begin
                valid_out_reg  <= 1'b1;
                data_e_reg     <= addr_reg;
                crt_wb_reg     <= crt_reg;
                rd_out_reg     <= rd_reg;
                reg_we_out_reg <= done & we_reg & !wr_reg;
                exc_reg        <= done ? 2'b00 : 2'b10;
                if (done && !wr_reg)
                    data_m_reg <= load_fmt;
            end else begin
                valid_out_reg  <= 1'b0;
                reg_we_out_reg <= 1'b0;
                exc_reg        <= 2'b00;
            end
        end else if (start) begin
            valid_out_reg  <= 1'b0;
            reg_we_out_reg <= 1'b0;
            exc_reg        <= 2'b00;
        end else begin
            // Plain ALU result, bubble, or a faulting memory op retiring immediately
            data_e_reg <= ADDR;
            crt_wb_reg <= CRT_WB_IN;
            rd_out_reg <= RD_ADDR_IN;
            if (mem_op) begin
                valid_out_reg  <= 1'b1;
                reg_we_out_reg <= 1'b0;
                exc_reg        <= illegal ? 2'b11 : 2'b01;
            end else begin
                valid_out_reg  <= VALID_IN;
                reg_we_out_reg <= REG_WE_IN & VALID_IN;
                exc_reg        <= 2'b00;
            end
        end
    end

    assign VALID_OUT   = valid_out_reg;
    assign DATA_M      = data_m_reg;
    assign DATA_E      = data_e_reg;
    assign CRT_WB      = crt_wb_reg;
    assign RD_ADDR_OUT = rd_out_reg;
    assign REG_WE_OUT  = reg_we_out_reg;
    assign EXC_OUT     = exc_reg;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: expected MEM/WB results are queued at issue
// and popped when the stage retires the instruction.
module tb_mem_stage_lsu;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VALID_IN, MEM_RD, MEM_WR, CRT_WB_IN, REG_WE_IN;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDR, STORE_DATA;
    logic [4:0]  RD_ADDR_IN;
    logic        STALL, DMEM_REQ, DMEM_WE, DMEM_READY;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [3:0]  DMEM_BE;
    logic        VALID_OUT, CRT_WB, REG_WE_OUT;
    logic [31:0] DATA_M, DATA_E;
    logic [4:0]  RD_ADDR_OUT;
    logic [1:0]  EXC_OUT;

    typedef struct {
        logic        valid;
        logic [31:0] data_m;
        logic [31:0] data_e;
        logic        crt;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  exc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    mem_stage_lsu #(.TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST), .VALID_IN(VALID_IN), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
        .FUNCT3(FUNCT3), .ADDR(ADDR), .STORE_DATA(STORE_DATA), .CRT_WB_IN(CRT_WB_IN),
        .RD_ADDR_IN(RD_ADDR_IN), .REG_WE_IN(REG_WE_IN), .STALL(STALL),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_READY(DMEM_READY), .DMEM_RDATA(DMEM_RDATA),
        .VALID_OUT(VALID_OUT), .DATA_M(DATA_M), .DATA_E(DATA_E), .CRT_WB(CRT_WB),
        .RD_ADDR_OUT(RD_ADDR_OUT), .REG_WE_OUT(REG_WE_OUT), .EXC_OUT(EXC_OUT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [31:0] dm, input logic [31:0] de,
                                input logic c, input logic [4:0] r, input logic w,
                                input logic [1:0] x);
        exp_t e;
        e.valid = v; e.data_m = dm; e.data_e = de; e.crt = c; e.rd = r; e.we = w; e.exc = x;
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        chk("sb_avail", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("valid_out", {31'd0, VALID_OUT}, {31'd0, e.valid});
            chk("data_m", DATA_M, e.data_m);
            chk("data_e", DATA_E, e.data_e);
            chk("crt_wb", {31'd0, CRT_WB}, {31'd0, e.crt});
            chk("rd_addr_out", {27'd0, RD_ADDR_OUT}, {27'd0, e.rd});
            chk("reg_we_out", {31'd0, REG_WE_OUT}, {31'd0, e.we});
            chk("exc_out", {30'd0, EXC_OUT}, {30'd0, e.exc});
            $display("retired rd=%0d data_e=%h data_m=%h exc=%0d", RD_ADDR_OUT, DATA_E, DATA_M, EXC_OUT);
        end
    endtask

    // Issues one instruction at the current (post-edge) time and follows it to retirement.
    task automatic do_op(input logic v_i, input logic rd_i, input logic wr_i, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic crt,
                         input logic [4:0] rd, input logic we, input bit mem_path,
                         input int n_low, input bit do_ready, input logic [31:0] rdata,
                         input logic [31:0] e_daddr, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input exp_t e);
        int stall_cnt;
        VALID_IN = v_i; MEM_RD = rd_i; MEM_WR = wr_i; FUNCT3 = f3; ADDR = addr;
        STORE_DATA = sd; CRT_WB_IN = crt; RD_ADDR_IN = rd; REG_WE_IN = we;
        sb.push_back(e);
        #1;
        if (!mem_path) begin
            chk("stall_nonacc", {31'd0, STALL}, 32'd0);
            chk("req_nonacc", {31'd0, DMEM_REQ}, 32'd0);
            @(posedge CLK); #1;
        end else begin
            chk("stall_capture", {31'd0, STALL}, 32'd1);
            chk("req_capture", {31'd0, DMEM_REQ}, 32'd0);
            stall_cnt = 1;
            @(posedge CLK); #1;
            for (int i = 0; i < n_low; i++) begin
                chk("req_wait", {31'd0, DMEM_REQ}, 32'd1);
                chk("daddr_wait", DMEM_ADDR, e_daddr);
                chk("stall_wait", {31'd0, STALL},
                    (!do_ready && i == n_low - 1) ? 32'd0 : 32'd1);
                if (STALL) stall_cnt++;
                @(posedge CLK); #1;
            end
            if (do_ready) begin
                DMEM_READY = 1'b1; DMEM_RDATA = rdata;
                #1;
                chk("req_ready", {31'd0, DMEM_REQ}, 32'd1);
                chk("daddr", DMEM_ADDR, e_daddr);
                chk("be", {28'd0, DMEM_BE}, {28'd0, e_be});
                chk("we", {31'd0, DMEM_WE}, {31'd0, wr_i});
                if (wr_i) chk("wdata", DMEM_WDATA, e_wdata);
                chk("stall_ready", {31'd0, STALL}, 32'd0);
                chk("stall_cycles", stall_cnt, 1 + n_low);
                @(posedge CLK); #1;
                DMEM_READY = 1'b0;
            end
        end
        VALID_IN = 1'b0; MEM_RD = 1'b0; MEM_WR = 1'b0;
        compare_out();
        @(posedge CLK); #1;
        chk("valid_pulse", {31'd0, VALID_OUT}, 32'd0);
        chk("we_pulse", {31'd0, REG_WE_OUT}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; VALID_IN = 0; MEM_RD = 0; MEM_WR = 0; FUNCT3 = 0; ADDR = 0;
        STORE_DATA = 0; CRT_WB_IN = 0; RD_ADDR_IN = 0; REG_WE_IN = 0;
        DMEM_READY = 0; DMEM_RDATA = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", {31'd0, VALID_OUT}, 32'd0);
        chk("rst_data_m", DATA_M, 32'd0);
        chk("rst_data_e", DATA_E, 32'd0);
        chk("rst_stall", {31'd0, STALL}, 32'd0);
        chk("rst_req", {31'd0, DMEM_REQ}, 32'd0);
        chk("rst_exc", {30'd0, EXC_OUT}, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // ALU op passthrough
        do_op(1, 0, 0, 3'b000, 32'h1234, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,
              mk(1, 32'h0, 32'h1234, 1, 5, 1, 2'b00));
        // LB / LBU at byte lane 3, three wait cycles
        do_op(1, 1, 0, 3'b000, 32'h103, 0, 0, 6, 1, 1, 3, 1, 32'h80FF_0000, 32'h100, 4'hF, 0,
              mk(1, 32'hFFFF_FF80, 32'h103, 0, 6, 1, 2'b00));
        do_op(1, 1, 0, 3'b100, 32'h103, 0, 0, 6, 1, 1, 3, 1, 32'h80FF_0000, 32'h100, 4'hF, 0,
              mk(1, 32'h0000_0080, 32'h103, 0, 6, 1, 2'b00));
        // SH upper half, SB lane 1
        do_op(1, 0, 1, 3'b001, 32'h202, 32'hAAAA_BEEF, 0, 7, 1, 1, 0, 1, 0, 32'h200, 4'b1100,
              32'hBEEF_BEEF, mk(1, 32'h80, 32'h202, 0, 7, 0, 2'b00));
        do_op(1, 0, 1, 3'b000, 32'h101, 32'h1234_5678, 0, 8, 1, 1, 1, 1, 0, 32'h100, 4'b0010,
              32'h7878_7878, mk(1, 32'h80, 32'h101, 0, 8, 0, 2'b00));
        // LH upper half sign-extended, LHU lower half
        do_op(1, 1, 0, 3'b001, 32'h002, 0, 0, 9, 1, 1, 2, 1, 32'h8001_7FFF, 32'h0, 4'hF, 0,
              mk(1, 32'hFFFF_8001, 32'h002, 0, 9, 1, 2'b00));
        do_op(1, 1, 0, 3'b101, 32'h000, 0, 0, 9, 1, 1, 0, 1, 32'h8001_7FFF, 32'h0, 4'hF, 0,
              mk(1, 32'h0000_7FFF, 32'h000, 0, 9, 1, 2'b00));
        // Misaligned LW, illegal load funct3, illegal+misaligned store, RD&WR both
        do_op(1, 1, 0, 3'b010, 32'h301, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0,
              mk(1, 32'h7FFF, 32'h301, 0, 10, 0, 2'b01));
        do_op(1, 1, 0, 3'b011, 32'h000, 0, 0, 11, 1, 0, 0, 0, 0, 0, 0, 0,
              mk(1, 32'h7FFF, 32'h000, 0, 11, 0, 2'b11));
        do_op(1, 0, 1, 3'b110, 32'h002, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0,
              mk(1, 32'h7FFF, 32'h002, 0, 12, 0, 2'b11));
        do_op(1, 1, 1, 3'b010, 32'h020, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0,
              mk(1, 32'h7FFF, 32'h020, 0, 12, 0, 2'b11));
        // Bubble
        do_op(0, 0, 0, 3'b000, 32'h55, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0,
              mk(0, 32'h7FFF, 32'h55, 1, 3, 0, 2'b00));
        // Timeout after 16 ACCESS cycles, then READY exactly on cycle 16
        do_op(1, 1, 0, 3'b010, 32'h400, 0, 0, 13, 1, 1, 16, 0, 0, 32'h400, 4'hF, 0,
              mk(1, 32'h7FFF, 32'h400, 0, 13, 0, 2'b10));
        do_op(1, 1, 0, 3'b010, 32'h404, 0, 1, 14, 1, 1, 15, 1, 32'hCAFE_F00D, 32'h404, 4'hF, 0,
              mk(1, 32'hCAFE_F00D, 32'h404, 1, 14, 1, 2'b00));

        // Reset on the second ACCESS cycle aborts the access
        VALID_IN = 1; MEM_RD = 1; MEM_WR = 0; FUNCT3 = 3'b010; ADDR = 32'h500;
        RD_ADDR_IN = 5'd20; REG_WE_IN = 1; CRT_WB_IN = 1;
        #1;
        chk("abort_capture_stall", {31'd0, STALL}, 32'd1);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("abort_req_before", {31'd0, DMEM_REQ}, 32'd1);
        RST = 1'b1; VALID_IN = 0; MEM_RD = 0;
        #1;
        chk("abort_req_in_rst", {31'd0, DMEM_REQ}, 32'd0);
        chk("abort_stall_in_rst", {31'd0, STALL}, 32'd0);
        @(posedge CLK); #1;
        chk("abort_req", {31'd0, DMEM_REQ}, 32'd0);
        chk("abort_stall", {31'd0, STALL}, 32'd0);
        chk("abort_valid", {31'd0, VALID_OUT}, 32'd0);
        chk("abort_data_m", DATA_M, 32'd0);
        chk("abort_data_e", DATA_E, 32'd0);
        chk("abort_rd", {27'd0, RD_ADDR_OUT}, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        do_op(1, 1, 0, 3'b010, 32'h000, 0, 0, 15, 1, 1, 0, 1, 32'h1, 32'h0, 4'hF, 0,
              mk(1, 32'h1, 32'h0, 0, 15, 1, 2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
